fetch_decode_latch: RTL and testbench
=====================================

// Module: fetch_decode_latch
// PURPOSE
//  IF/ID pipeline register of the 5-stage pipeline. Captures the fetched instruction/PC+4 and
//  feeds FDIFinst to decode and to the hazard unit. Obeys the hazard unit's stallFD/flushFD/
//  flushHALT. Holds one instruction in a skid entry when a fetch completes during a stall.
//  Keeps saturating instruction/bubble counters for perf debug.
// PARAMETERS
//  WORD_W    32     instruction/PC width (word_t)
//  CNT_W     16     width of inst_cnt / bubble_cnt (saturating)
//  NOP_WORD  32'h0  value loaded into FDIFinst on bubble/flush (sll $0,$0,0)
// PORTS
//  CLK         in   1       clock, rising edge
//  RST         in   1       asynchronous, active-high reset
//  ihit        in   1       imemload/pc4 valid this cycle
//  imemload    in   WORD_W  fetched instruction
//  pc4         in   WORD_W  PC+4 of fetched instruction
//  stallFD     in   1       hazard unit: hold latch contents
//  flushFD     in   1       hazard unit: squash latch to bubble
//  flushHALT   in   1       hazard unit: squash and freeze until reset
//  FDIFinst    out  WORD_W  instruction presented to decode/hazard unit
//  fdif_pc4    out  WORD_W  PC+4 of FDIFinst
//  fdif_valid  out  1       FDIFinst is a real instruction (0 = bubble)
//  fetch_hold  out  1       fetch must not advance PC (== skid_full)
//  skid_full   out  1       skid entry occupied
//  halted      out  1       state == HALTED
//  inst_cnt    out  CNT_W   valid instructions loaded into latch
//  bubble_cnt  out  CNT_W   bubbles loaded into latch
// BEHAVIOUR
//  - Reset (async, RST=1): FDIFinst=NOP_WORD, fdif_pc4=0, fdif_valid=0, skid cleared,
//    counters 0, state RUN; fetch_hold/skid_full/halted=0. Holds while RST high.
//  - States: RUN (skid empty), SKID (skid full), HALTED. fetch_hold/skid_full are registered
//    state decodes, not combinational from stallFD.
//  - Per-edge priority: flushHALT > flushFD > stallFD > load.
//  - flushHALT: latch <- bubble, skid cleared, ->HALTED. HALTED ignores all inputs incl. further
//    flushes; latch stays bubble, counters frozen; exit only via RST.
//  - flushFD (not HALTED): latch <- bubble, skid cleared (skid instr discarded; fetch refetches),
//    ->RUN. Flush overrides a simultaneous stallFD. bubble_cnt+1.
//  - RUN, stallFD=1: latch held. If ihit=1 capture {imemload,pc4} into skid, ->SKID. No counts.
//  - SKID, stallFD=1: latch and skid held; ihit ignored (fetch is held by fetch_hold).
//  - SKID, stallFD=0: latch <- skid (valid=1), skid cleared, ->RUN; ihit this cycle ignored.
//    inst_cnt+1.
//  - RUN, stallFD=0, ihit=1: latch <- {imemload,pc4}, valid=1, inst_cnt+1.
//  - RUN, stallFD=0, ihit=0: latch <- bubble, valid=0, bubble_cnt+1.
//  - Latency: instruction visible on FDIFinst 1 cycle after its ihit edge (unstalled); stall->
//    release adds exactly the stall length; skid never drops or duplicates an instruction.
//  - Counters saturate at 2^CNT_W-1 (no wrap); both never increment in the same cycle.
// TESTING
//  1 Load: ihit=1, imemload=32'h20010005, pc4=32'h4 -> next edge FDIFinst=20010005,
//    fdif_pc4=4, fdif_valid=1, inst_cnt=1.
//  2 Skid: latch=A(32'h8C220004); stallFD=1, ihit=1, imemload=B(32'h00221820) -> FDIFinst
//    stays A, skid_full=1, fetch_hold=1; 3 stall cycles with ihit=1, C -> no change; stallFD=0
//    -> FDIFinst=B, skid_full=0, C never appears.
//  3 Flush beats stall: SKID state, stallFD=1 & flushFD=1 -> FDIFinst=0, fdif_valid=0,
//    skid_full=0, bubble_cnt+1, inst_cnt unchanged.
//  4 Halt: flushHALT=1 -> halted=1, FDIFinst=0; 10 cycles of ihit=1/varied inst/flushFD ->
//    outputs and counters unchanged; RST pulse -> RUN, counters 0.
//  5 Async reset mid-stall: SKID state, assert RST between edges -> all outputs at reset
//    values before next CLK edge; deassert -> normal load resumes.
//  6 Saturation (CNT_W=4): 20 cycles ihit=0 -> bubble_cnt=15, inst_cnt=0.

Source files
------------

// File: rtl/fd_if.sv
// IF/ID bundle: fetch + hazard-unit controls in, decoded-side latch view and perf counters out.
interface fd_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
);
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic [WORD_W-1:0] pc4;
    logic              stallFD;
    logic              flushFD;
    logic              flushHALT;
    logic [WORD_W-1:0] FDIFinst;
    logic [WORD_W-1:0] fdif_pc4;
    logic              fdif_valid;
    logic              fetch_hold;
    logic              skid_full;
    logic              halted;
    logic [CNT_W-1:0]  inst_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output ihit, imemload, pc4, stallFD, flushFD, flushHALT,
        input  FDIFinst, fdif_pc4, fdif_valid, fetch_hold, skid_full, halted,
               inst_cnt, bubble_cnt
    );

    modport slave (
        input  ihit, imemload, pc4, stallFD, flushFD, flushHALT,
        output FDIFinst, fdif_pc4, fdif_valid, fetch_hold, skid_full, halted,
               inst_cnt, bubble_cnt
    );
endinterface

// File: rtl/fetch_decode_latch.sv
// IF/ID pipeline register with a one-entry skid buffer for fetches that land during a stall,
// sticky halt, and saturating instruction/bubble counters.
module fetch_decode_latch #(
    parameter int                WORD_W   = 32,
    parameter int                CNT_W    = 16,
    parameter logic [WORD_W-1:0] NOP_WORD = '0
) (
    input logic clk,
    input logic rst,
    fd_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SKID   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] inst_q, inst_d;
    logic [WORD_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] skid_inst_q, skid_inst_d;
    logic [WORD_W-1:0] skid_pc4_q, skid_pc4_d;
    logic [CNT_W-1:0]  inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic              inst_inc, bubble_inc;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through this block infers a latch.
        state_d     = state_q;
        inst_d      = inst_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        skid_inst_d = skid_inst_q;
        skid_pc4_d  = skid_pc4_q;
        inst_inc    = 1'b0;
        bubble_inc  = 1'b0;

        if (state_q == ST_HALTED) begin
            // Frozen until reset; every input, including further flushes, is ignored.
        end else if (bus.flushHALT) begin
            inst_d      = NOP_WORD;
            pc4_d       = '0;
            valid_d     = 1'b0;
            skid_inst_d = '0;
            skid_pc4_d  = '0;
            state_d     = ST_HALTED;
        end else if (bus.flushFD) begin
            // Any skid instruction is dropped: fetch refetches it after the redirect.
            inst_d      = NOP_WORD;
            pc4_d       = '0;
            valid_d     = 1'b0;
            skid_inst_d = '0;
            skid_pc4_d  = '0;
            state_d     = ST_RUN;
            bubble_inc  = 1'b1;
        end else if (bus.stallFD) begin
            if (state_q == ST_RUN && bus.ihit) begin
                skid_inst_d = bus.imemload;
                skid_pc4_d  = bus.pc4;
                state_d     = ST_SKID;
            end
        end else if (state_q == ST_SKID) begin
            // Fetch was held by fetch_hold, so any ihit this cycle is not a new instruction.
            inst_d      = skid_inst_q;
            pc4_d       = skid_pc4_q;
            valid_d     = 1'b1;
            skid_inst_d = '0;
            skid_pc4_d  = '0;
            state_d     = ST_RUN;
            inst_inc    = 1'b1;
        end else if (bus.ihit) begin
            inst_d   = bus.imemload;
            pc4_d    = bus.pc4;
            valid_d  = 1'b1;
            inst_inc = 1'b1;
        end else begin
            inst_d     = NOP_WORD;
            pc4_d      = '0;
            valid_d    = 1'b0;
            bubble_inc = 1'b1;
        end

        inst_cnt_d   = (inst_inc && inst_cnt_q != '1) ? inst_cnt_q + 1'b1 : inst_cnt_q;
        bubble_cnt_d = (bubble_inc && bubble_cnt_q != '1) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            inst_q       <= NOP_WORD;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc4_q   <= '0;
            inst_cnt_q   <= '0;
            bubble_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q      <= state_d;
            inst_q       <= inst_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc4_q   <= skid_pc4_d;
            inst_cnt_q   <= inst_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.FDIFinst   = inst_q;
    assign bus.fdif_pc4   = pc4_q;
    assign bus.fdif_valid = valid_q;
    assign bus.skid_full  = (state_q == ST_SKID);
    assign bus.fetch_hold = (state_q == ST_SKID);
    assign bus.halted     = (state_q == ST_HALTED);
    assign bus.inst_cnt   = inst_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_fetch_decode_latch.sv
// Directed scenarios followed by random traffic, all compared against a transaction-level model.
module tb_fetch_decode_latch;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fd_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus();

    fetch_decode_latch #(.WORD_W(WORD_W), .CNT_W(CNT_W), .NOP_WORD(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } entry_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: latch contents, pending skid queue, halt flag, integer counters.
    logic [31:0] m_inst, m_pc4;
    logic        m_valid;
    entry_t      m_skid[$];
    bit          m_halted;
    int          m_icnt, m_bcnt;

    function automatic void model_reset();
        m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_skid.delete(); m_halted = 1'b0; m_icnt = 0; m_bcnt = 0;
    endfunction

    function automatic void model_bubble();
        m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endfunction

    function automatic void model_step(bit ihit, logic [31:0] inst, logic [31:0] pc4,
                                       bit stall, bit flush, bit halt);
        entry_t e;
        if (m_halted) return;
        if (halt) begin
            model_bubble(); m_skid.delete(); m_halted = 1'b1;
        end else if (flush) begin
            model_bubble(); m_skid.delete();
            if (m_bcnt < CNT_MAX) m_bcnt++;
        end else if (stall) begin
            if (m_skid.size() == 0 && ihit) begin
                e.inst = inst; e.pc4 = pc4;
                m_skid.push_back(e);
            end
        end else if (m_skid.size() != 0) begin
            e = m_skid.pop_front();
            m_inst = e.inst; m_pc4 = e.pc4; m_valid = 1'b1;
            if (m_icnt < CNT_MAX) m_icnt++;
        end else if (ihit) begin
            m_inst = inst; m_pc4 = pc4; m_valid = 1'b1;
            if (m_icnt < CNT_MAX) m_icnt++;
        end else begin
            model_bubble();
            if (m_bcnt < CNT_MAX) m_bcnt++;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit full;
        full = (m_skid.size() != 0);
        check({tag, ".inst"},   bus.FDIFinst, m_inst);
        check({tag, ".pc4"},    bus.fdif_pc4, m_pc4);
        check({tag, ".valid"},  32'(bus.fdif_valid), 32'(m_valid));
        check({tag, ".skid"},   32'(bus.skid_full), 32'(full));
        check({tag, ".hold"},   32'(bus.fetch_hold), 32'(full));
        check({tag, ".halted"}, 32'(bus.halted), 32'(m_halted));
        check({tag, ".icnt"},   32'(bus.inst_cnt), 32'(m_icnt));
        check({tag, ".bcnt"},   32'(bus.bubble_cnt), 32'(m_bcnt));
    endtask

    task automatic drive(input bit ihit, input logic [31:0] inst, input logic [31:0] pc4,
                         input bit stall, input bit flush, input bit halt);
        bus.ihit = ihit; bus.imemload = inst; bus.pc4 = pc4;
        bus.stallFD = stall; bus.flushFD = flush; bus.flushHALT = halt;
    endtask

    // One clock: model consumes the stable inputs, DUT is sampled 1 time unit after the edge.
    task automatic cycle(input string tag);
        model_step(bus.ihit, bus.imemload, bus.pc4, bus.stallFD, bus.flushFD, bus.flushHALT);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Reset pulse placed between edges; outputs must clear before any clock edge.
    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int cnt_i, cnt_b, halt_age;
        bit ih, st, fl, ht;

        drive(0, 32'h0, 32'h0, 0, 0, 0);
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk); #1;
        check_all("reset_hold");
        rst = 1'b0;

        // 1: simple load
        drive(1, 32'h20010005, 32'h4, 0, 0, 0);
        cycle("load");
        check("load.const_inst", bus.FDIFinst, 32'h20010005);
        check("load.const_pc4", bus.fdif_pc4, 32'h4);
        check("load.const_icnt", 32'(bus.inst_cnt), 32'd1);

        // 2: skid capture, held stall, release
        drive(1, 32'h8C220004, 32'h8, 0, 0, 0);
        cycle("loadA");
        drive(1, 32'h00221820, 32'hC, 1, 0, 0);
        cycle("skidB");
        check("skidB.const_inst", bus.FDIFinst, 32'h8C220004);
        check("skidB.const_full", 32'(bus.skid_full), 32'd1);
        drive(1, 32'hDEADBEEF, 32'h10, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle("stallC");
        check("stallC.const_inst", bus.FDIFinst, 32'h8C220004);
        drive(1, 32'hDEADBEEF, 32'h10, 0, 0, 0);
        cycle("releaseB");
        check("releaseB.const_inst", bus.FDIFinst, 32'h00221820);
        check("releaseB.const_full", 32'(bus.skid_full), 32'd0);
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        cycle("idle");

        // 3: flush beats stall while skid is full
        drive(1, 32'h11111111, 32'h14, 1, 0, 0);
        cycle("skidD");
        cnt_i = m_icnt; cnt_b = m_bcnt;
        drive(1, 32'h22222222, 32'h18, 1, 1, 0);
        cycle("flush_stall");
        check("flush_stall.const_valid", 32'(bus.fdif_valid), 32'd0);
        check("flush_stall.bcnt_inc", 32'(bus.bubble_cnt), 32'(cnt_b + 1));
        check("flush_stall.icnt_same", 32'(bus.inst_cnt), 32'(cnt_i));

        // 4: halt freezes everything until reset
        drive(1, 32'h33333333, 32'h1C, 0, 0, 1);
        cycle("halt");
        check("halt.const_halted", 32'(bus.halted), 32'd1);
        cnt_i = m_icnt; cnt_b = m_bcnt;
        for (int i = 0; i < 10; i++) begin
            drive(1, $urandom, $urandom, 0, i[0], 0);
            cycle("halted");
        end
        check("halted.icnt_frozen", 32'(bus.inst_cnt), 32'(cnt_i));
        check("halted.bcnt_frozen", 32'(bus.bubble_cnt), 32'(cnt_b));
        reset_pulse("halt_rst");
        check("halt_rst.const_halted", 32'(bus.halted), 32'd0);
        drive(1, 32'h44444444, 32'h20, 0, 0, 0);
        cycle("post_halt_load");

        // 5: async reset while the skid is full
        drive(1, 32'h55555555, 32'h24, 1, 0, 0);
        cycle("skidE");
        #2;
        reset_pulse("async_rst");
        check("async_rst.const_inst", bus.FDIFinst, 32'h0);
        check("async_rst.const_full", 32'(bus.skid_full), 32'd0);
        drive(1, 32'h66666666, 32'h28, 0, 0, 0);
        cycle("resume");
        check("resume.const_inst", bus.FDIFinst, 32'h66666666);

        // 6: bubble counter saturation
        reset_pulse("sat_rst");
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle("sat");
        check("sat.const_bcnt", 32'(bus.bubble_cnt), 32'd15);
        check("sat.const_icnt", 32'(bus.inst_cnt), 32'd0);

        // Random traffic; halted periods end with a reset pulse.
        halt_age = 0;
        for (int i = 0; i < 500; i++) begin
            ih = ($urandom_range(99) < 70);
            st = ($urandom_range(99) < 35);
            fl = ($urandom_range(99) < 5);
            ht = ($urandom_range(199) == 0);
            drive(ih, $urandom, $urandom, st, fl, ht);
            cycle("rand");
            if (m_halted) halt_age++;
            if (halt_age > 3 || $urandom_range(149) == 0) begin
                reset_pulse("rand_rst");
                halt_age = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
